// File: rtl/gf256_serial_mult_if.sv
// gf256_serial_mult_if
// Operand and product handshake bundle for the serial GF(2^8) multiplier.
//   in_valid  / in_ready  : operand handshake (a = multiplicand, b = multiplier)
//   out_valid / out_ready : product handshake (p = a*b in GF(2^8))
//   busy                  : multiplier is iterating
// master: the side that supplies operands and consumes products.
// slave : the multiplier itself.
interface gf256_serial_mult_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;
    logic       busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/gf256_serial_mult.sv
// gf256_serial_mult
// Sequential GF(2^8) multiplier over x^8+x^4+x^3+x+1 (0x11B) using
// shift-and-add: each clock conditionally accumulates the multiplicand,
// then multiplies it by x (xtime) and shifts the multiplier right.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of gf256_serial_mult_if (in_valid/in_ready/a/b,
//          out_valid/out_ready/p, busy)
// Parameter:
//   EARLY_EXIT : 0 = always 8 iterations, 1 = stop once the remaining
//                multiplier bits are all zero (minimum one iteration).
module gf256_serial_mult #(
    parameter int EARLY_EXIT = 0
) (
    input logic               clk,
    input logic               rst,
    gf256_serial_mult_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] acc;
    logic [7:0] p_reg;
    logic [2:0] cnt;
    logic       in_ready_reg;
    logic       out_valid_reg;
    logic       busy_reg;

    logic [7:0] acc_next;
    logic [7:0] a_xtime;
    logic [7:0] b_shift;
    logic       last_iter;

    // One shift-and-add step: add the current multiple of a when the low
    // multiplier bit is set, then advance a to a*x with the 0x1B reduction.
    assign acc_next  = acc ^ (b_reg[0] ? a_reg : 8'h00);
    assign a_xtime   = {a_reg[6:0], 1'b0} ^ (a_reg[7] ? 8'h1B : 8'h00);
    assign b_shift   = {1'b0, b_reg[7:1]};

    // The eighth iteration always ends the run; with early exit the run
    // also ends once no multiplier bits remain to be consumed.
    assign last_iter = (cnt == 3'd7) || ((EARLY_EXIT != 0) && (b_shift == 8'h00));

    // Control FSM and datapath share one register block so every output
    // changes in step with the state it is decoded from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a_reg         <= 8'h00;
            b_reg         <= 8'h00;
            acc           <= 8'h00;
            cnt           <= 3'd0;
            p_reg         <= 8'h00;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        acc          <= 8'h00;
                        cnt          <= 3'd0;
                        state        <= CALC;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    a_reg <= a_xtime;
                    b_reg <= b_shift;
                    cnt   <= cnt + 3'd1;
                    if (last_iter) begin
                        p_reg         <= acc_next;
                        state         <= DONE;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // No new operands are taken on the draining edge.
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.p         = p_reg;

endmodule

// File: tb/tb_gf256_serial_mult.sv
// tb_gf256_serial_mult
// Exercises two multiplier instances (EARLY_EXIT=0 and EARLY_EXIT=1)
// with directed and random transactions, comparing products and
// handshake timing against a polynomial-multiply-then-reduce model.
module tb_gf256_serial_mult;

    logic clk;
    logic rst;

    logic       sel;
    logic       drv_in_valid;
    logic [7:0] drv_a;
    logic [7:0] drv_b;
    logic       drv_out_ready;

    int errors;
    int checks;
    logic [7:0] last_p [2];

    gf256_serial_mult_if if0 ();
    gf256_serial_mult_if if1 ();

    gf256_serial_mult #(.EARLY_EXIT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    gf256_serial_mult #(.EARLY_EXIT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    // Only the selected instance sees handshakes; operands go to both.
    assign if0.in_valid  = drv_in_valid  & ~sel;
    assign if1.in_valid  = drv_in_valid  &  sel;
    assign if0.out_ready = drv_out_ready & ~sel;
    assign if1.out_ready = drv_out_ready &  sel;
    assign if0.a = drv_a;
    assign if0.b = drv_b;
    assign if1.a = drv_a;
    assign if1.b = drv_b;

    logic       obs_in_ready;
    logic       obs_out_valid;
    logic       obs_busy;
    logic [7:0] obs_p;

    assign obs_in_ready  = sel ? if1.in_ready  : if0.in_ready;
    assign obs_out_valid = sel ? if1.out_valid : if0.out_valid;
    assign obs_busy      = sel ? if1.busy      : if0.busy;
    assign obs_p         = sel ? if1.p         : if0.p;

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: carry-less 8x8 product, then reduce modulo 0x11B.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (y[i]) prod = prod ^ (16'(x) << i);
        for (int i = 14; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        return prod[7:0];
    endfunction

    // Number of edges from acceptance to out_valid.
    function automatic int exp_latency(input logic s, input logic [7:0] y);
        int k;
        if (!s) return 8;
        k = 1;
        for (int i = 0; i < 8; i++)
            if (y[i]) k = i + 1;
        return k;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full transaction on the selected instance. Operands and in_valid
    // are scrambled while it computes; during stall cycles a fresh operand
    // (a=0xFF) is offered and must be ignored.
    task automatic applyStimulus(input logic s, input logic [7:0] av, input logic [7:0] bv,
                                 input logic [7:0] exp_p, input int stall);
        int lat;
        sel = s;
        drv_in_valid  = 1'b0;
        drv_out_ready = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(obs_in_ready), 32'd1);
        drv_a        = av;
        drv_b        = bv;
        drv_in_valid = 1'b1;
        @(negedge clk);
        checkOutput("busy_calc", 32'(obs_busy), 32'd1);
        checkOutput("in_ready_calc", 32'(obs_in_ready), 32'd0);
        checkOutput("p_kept_calc", 32'(obs_p), 32'(last_p[s]));
        lat = 0;
        while (obs_out_valid !== 1'b1 && lat < 20) begin
            drv_a         = 8'($urandom);
            drv_b         = 8'($urandom);
            drv_in_valid  = 1'($urandom);
            drv_out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        drv_out_ready = 1'b0;
        checkOutput("latency", 32'(lat), 32'(exp_latency(s, bv)));
        checkOutput("p", 32'(obs_p), 32'(exp_p));
        for (int i = 0; i < stall; i++) begin
            drv_in_valid = 1'b1;
            drv_a        = 8'hFF;
            drv_b        = 8'($urandom);
            @(negedge clk);
            checkOutput("p_held", 32'(obs_p), 32'(exp_p));
            checkOutput("out_valid_held", 32'(obs_out_valid), 32'd1);
            checkOutput("in_ready_stall", 32'(obs_in_ready), 32'd0);
        end
        drv_in_valid  = 1'b0;
        drv_out_ready = 1'b1;
        @(negedge clk);
        drv_out_ready = 1'b0;
        checkOutput("out_valid_drop", 32'(obs_out_valid), 32'd0);
        checkOutput("in_ready_back", 32'(obs_in_ready), 32'd1);
        checkOutput("p_after_drain", 32'(obs_p), 32'(exp_p));
        last_p[s] = exp_p;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        errors        = 0;
        checks        = 0;
        last_p[0]     = 8'h00;
        last_p[1]     = 8'h00;
        sel           = 1'b0;
        drv_in_valid  = 1'b0;
        drv_out_ready = 1'b0;
        drv_a         = 8'h00;
        drv_b         = 8'h00;
        rst           = 1'b1;

        #12;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checkOutput("rst_in_ready", 32'(obs_in_ready), 32'd1);
            checkOutput("rst_out_valid", 32'(obs_out_valid), 32'd0);
            checkOutput("rst_busy", 32'(obs_busy), 32'd0);
            checkOutput("rst_p", 32'(obs_p), 32'h00);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed products, EARLY_EXIT=0");
        applyStimulus(1'b0, 8'h57, 8'h83, 8'hC1, 0);
        applyStimulus(1'b0, 8'h57, 8'h13, 8'hFE, 0);
        applyStimulus(1'b0, 8'h87, 8'h02, 8'h15, 1);
        applyStimulus(1'b0, 8'h57, 8'h01, 8'h57, 0);
        applyStimulus(1'b0, 8'hA5, 8'h00, 8'h00, 0);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 8'h57, 8'h02, 8'hAE, 5);

        $display("[TB] directed products, EARLY_EXIT=1");
        applyStimulus(1'b1, 8'h57, 8'h01, 8'h57, 0);
        applyStimulus(1'b1, 8'h57, 8'h13, 8'hFE, 0);
        applyStimulus(1'b1, 8'h57, 8'h80, gf_mul(8'h57, 8'h80), 2);
        applyStimulus(1'b1, 8'hA5, 8'h00, 8'h00, 0);
        applyStimulus(1'b1, 8'h57, 8'h83, 8'hC1, 0);

        $display("[TB] reset during CALC");
        sel          = 1'b0;
        drv_a        = 8'h57;
        drv_b        = 8'h83;
        drv_in_valid = 1'b1;
        @(negedge clk);
        drv_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_before_rst", 32'(obs_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_in_ready", 32'(obs_in_ready), 32'd1);
        checkOutput("arst_out_valid", 32'(obs_out_valid), 32'd0);
        checkOutput("arst_busy", 32'(obs_busy), 32'd0);
        checkOutput("arst_p", 32'(obs_p), 32'h00);
        @(negedge clk);
        rst       = 1'b0;
        last_p[0] = 8'h00;
        last_p[1] = 8'h00;
        applyStimulus(1'b0, 8'h57, 8'h83, 8'hC1, 0);

        $display("[TB] random regression");
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(1'(n % 2), ra, rb, gf_mul(ra, rb), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
